// File: rtl/superscalar_pkg.sv
// superscalar_pkg: shared widths, fetch-queue entry type and slot-count helper
package superscalar_pkg;
  localparam int PC_WIDTH = 16;
  localparam int INSTR_WIDTH = 32;
  typedef struct packed {
    logic pred;
    logic [PC_WIDTH-1:0] pc2;
    logic [INSTR_WIDTH-1:0] instr;
  } fq_entry_t;
  function automatic logic [1:0] fq_cnt(input logic [1:0] v);
    return v == 2'b11 ? 2'd2 : v == 2'b01 ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side push, decode-side pop and flush signals of the fetch queue
interface fetch_queue_if #(
  parameter int DEPTH = 8,
  parameter int PC_WIDTH = superscalar_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = superscalar_pkg::INSTR_WIDTH
);
  logic flush;
  logic [1:0] push_valid;
  logic [PC_WIDTH-1:0] push_pc2_0, push_pc2_1;
  logic [INSTR_WIDTH-1:0] push_instr0, push_instr1;
  logic push_pred0, push_pred1;
  logic in_ready;
  logic [1:0] out_valid;
  logic [PC_WIDTH-1:0] out_pc2_0, out_pc2_1;
  logic [INSTR_WIDTH-1:0] out_instr0, out_instr1;
  logic out_pred0, out_pred1;
  logic deq_ready;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output flush, push_valid, push_pc2_0, push_pc2_1, push_instr0, push_instr1,
           push_pred0, push_pred1, deq_ready,
    input in_ready, out_valid, out_pc2_0, out_pc2_1, out_instr0, out_instr1,
          out_pred0, out_pred1, count
  );
  modport slave (
    input flush, push_valid, push_pc2_0, push_pc2_1, push_instr0, push_instr1,
          push_pred0, push_pred1, deq_ready,
    output in_ready, out_valid, out_pc2_0, out_pc2_1, out_instr0, out_instr1,
           out_pred0, out_pred1, count
  );
endinterface

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH-entry register array, two write ports, two asynchronous read ports
module fetch_queue_mem #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic we0,
  input  logic [$clog2(DEPTH)-1:0] wa0,
  input  superscalar_pkg::fq_entry_t wd0,
  input  logic we1,
  input  logic [$clog2(DEPTH)-1:0] wa1,
  input  superscalar_pkg::fq_entry_t wd1,
  input  logic [$clog2(DEPTH)-1:0] ra0,
  output superscalar_pkg::fq_entry_t rd0,
  input  logic [$clog2(DEPTH)-1:0] ra1,
  output superscalar_pkg::fq_entry_t rd1
);
  import superscalar_pkg::*;
  fq_entry_t mem [DEPTH];
  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
  // storage is deliberately unreset; slot 1 always targets a different address than slot 0
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: two-wide in-order fetch-to-decode queue; FETCHQ_BYPASS_EN enables empty-queue bypass
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PC_WIDTH = superscalar_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = superscalar_pkg::INSTR_WIDTH
) (
  input logic clk,
  input logic rst,
  fetch_queue_if.slave q
);
  import superscalar_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic [1:0] legal_v, mem_v, push_n, pop_n, wr_n;
  logic byp;
  fq_entry_t wd0, wd1, rd0, rd1;
  assign legal_v = q.push_valid == 2'b10 ? 2'b00 : q.push_valid;
  assign mem_v = {cnt >= CW'(2), cnt != '0};
`ifdef FETCHQ_BYPASS_EN
  assign byp = cnt == '0 && !q.flush;
`else
  assign byp = 1'b0;
`endif
  assign q.in_ready = cnt <= CW'(DEPTH - 2);
  assign push_n = q.in_ready && !q.flush ? fq_cnt(legal_v) : 2'd0;
  assign pop_n = q.deq_ready ? fq_cnt(mem_v) : 2'd0;
  assign wr_n = byp && q.deq_ready ? 2'd0 : push_n;
  assign wd0 = '{pred: q.push_pred0, pc2: q.push_pc2_0, instr: q.push_instr0};
  assign wd1 = '{pred: q.push_pred1, pc2: q.push_pc2_1, instr: q.push_instr1};
  assign q.count = cnt;
  assign q.out_valid = byp ? legal_v : mem_v;
  assign q.out_pc2_0 = byp ? q.push_pc2_0 : rd0.pc2;
  assign q.out_pc2_1 = byp ? q.push_pc2_1 : rd1.pc2;
  assign q.out_instr0 = byp ? q.push_instr0 : rd0.instr;
  assign q.out_instr1 = byp ? q.push_instr1 : rd1.instr;
  assign q.out_pred0 = byp ? q.push_pred0 : rd0.pred;
  assign q.out_pred1 = byp ? q.push_pred1 : rd1.pred;
  fetch_queue_mem #(.DEPTH(DEPTH)) mem (
    .clk(clk),
    .we0(wr_n != 2'd0), .wa0(tail), .wd0(wd0),
    .we1(wr_n[1]), .wa1(tail + AW'(1)), .wd1(wd1),
    .ra0(head), .rd0(rd0),
    .ra1(head + AW'(1)), .rd1(rd1)
  );
  // pointers and occupancy; flush empties the queue and drops any same-cycle push
  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      head <= head + AW'(pop_n);
      tail <= tail + AW'(wr_n);
      cnt <= cnt + CW'(wr_n) - CW'(pop_n);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue, follows FETCHQ_BYPASS_EN when defined
module tb_fetch_queue;
  import superscalar_pkg::*;
  localparam int DEPTH = 8;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int seq = 0;
  fq_entry_t sb [$];
  logic [1:0] pvs [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  fetch_queue_if #(.DEPTH(DEPTH)) qif ();
  fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(qif));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (seq %0d)", tag, got, exp, seq);
    end
  endtask
  task automatic cycle(input logic [1:0] pv, input logic fl, input logic dq, input logic r);
    fq_entry_t p0, p1, e0, e1;
    logic [1:0] lv, ev;
    logic byp, acc;
    int n;
    @(negedge clk);
    p0 = '{pred: seq[0], pc2: 16'(seq * 4 + 2), instr: 32'hC0DE0000 | 32'(seq)};
    p1 = '{pred: ~seq[0], pc2: 16'(seq * 4 + 4), instr: 32'hBEEF0000 | 32'(seq)};
    seq++;
    rst = r;
    qif.flush = fl;
    qif.deq_ready = dq;
    qif.push_valid = pv;
    qif.push_pc2_0 = p0.pc2;
    qif.push_pc2_1 = p1.pc2;
    qif.push_instr0 = p0.instr;
    qif.push_instr1 = p1.instr;
    qif.push_pred0 = p0.pred;
    qif.push_pred1 = p1.pred;
    #1;
    lv = pv == 2'b10 ? 2'b00 : pv;
    byp = BYP && sb.size() == 0 && !fl;
    ev = byp ? lv : {sb.size() >= 2, sb.size() >= 1};
    e0 = byp ? p0 : (sb.size() > 0 ? sb[0] : p0);
    e1 = byp ? p1 : (sb.size() > 1 ? sb[1] : p1);
    chk("count", 64'(qif.count), 64'(sb.size()));
    chk("in_ready", 64'(qif.in_ready), 64'(sb.size() <= DEPTH - 2));
    chk("out_valid", 64'(qif.out_valid), 64'(ev));
    if (ev[0]) chk("slot0", 64'({qif.out_pred0, qif.out_pc2_0, qif.out_instr0}), 64'(e0));
    if (ev[1]) chk("slot1", 64'({qif.out_pred1, qif.out_pc2_1, qif.out_instr1}), 64'(e1));
    acc = sb.size() <= DEPTH - 2 && !fl && lv != 2'b00;
    if (r || fl) sb.delete();
    else begin
      n = dq ? (sb.size() > 2 ? 2 : sb.size()) : 0;
      repeat (n) void'(sb.pop_front());
      if (acc && !(byp && dq)) begin
        sb.push_back(p0);
        if (lv[1]) sb.push_back(p1);
      end
    end
  endtask
  initial begin
    qif.flush = 1'b0;
    qif.deq_ready = 1'b0;
    qif.push_valid = 2'b00;
    repeat (2) @(posedge clk);
    cycle(2'b00, 0, 0, 0);
    cycle(2'b11, 0, 0, 0);
    repeat (5) cycle(2'b11, 0, 0, 0);
    cycle(2'b00, 0, 1, 0);
    repeat (4) cycle(2'b11, 0, 1, 0);
    cycle(2'b00, 0, 1, 0);
    cycle(2'b01, 0, 0, 0);
    cycle(2'b11, 1, 0, 0);
    cycle(2'b00, 0, 0, 0);
    cycle(2'b01, 0, 1, 0);
    cycle(2'b00, 0, 0, 0);
    cycle(2'b10, 0, 0, 0);
    cycle(2'b00, 0, 0, 0);
    cycle(2'b11, 0, 0, 0);
    cycle(2'b01, 0, 0, 1);
    cycle(2'b00, 0, 1, 0);
    repeat (400) cycle(pvs[$urandom_range(3)], $urandom_range(19) == 0, 1'($urandom_range(1)),
                       $urandom_range(59) == 0);
    repeat (6) cycle(2'b00, 0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
